octal_counter: RTL and testbench

- Free-running 3-bit (modulo-8) up-counter with count enable and carry-out.
- Carry-out allows several instances to be cascaded into wider counters: connect cy of one stage to en of the next.
- Synchronous leaf block with a single clock domain and no handshakes.

---
 rtl/octal_counter.sv | 18 +
 tb/tb_octal_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/octal_counter.sv
// octal_counter: modulo-2**WIDTH up-counter with count enable and cascadable carry-out
module octal_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cntr,
    output logic             cy
);
    logic [WIDTH-1:0] cntr_q, cntr_d;
    // next count: reset wins over enable, otherwise increment when enabled and hold when not
    always_comb cntr_d = !rst ? '0 : en ? cntr_q + WIDTH'(1) : cntr_q;
    // single count register, updated on every rising edge
    always_ff @(posedge clk) cntr_q <= cntr_d;
    assign cntr = cntr_q;
    assign cy   = rst & en & (&cntr_q);
endmodule

// File: tb/tb_octal_counter.sv
// tb_octal_counter: directed scoreboard bench for single and cascaded octal counters
module tb_octal_counter;
    logic       clk = 0;
    logic       rst = 0, en = 1, crst = 0;
    logic [2:0] cntr, c0_cntr, c1_cntr;
    logic       cy, c0_cy, c1_cy;
    logic       one = 1'b1;
    int         tests = 0, fails = 0, pulses = 0;

    typedef struct {
        string      name;
        bit         chan;
        logic [6:0] exp;
    } exp_t;
    exp_t q[$];
    event chk;

    octal_counter dut (.clk(clk), .rst(rst), .en(en), .cntr(cntr), .cy(cy));
    octal_counter c0 (.clk(clk), .rst(crst), .en(one), .cntr(c0_cntr), .cy(c0_cy));
    octal_counter c1 (.clk(clk), .rst(crst), .en(c0_cy), .cntr(c1_cntr), .cy(c1_cy));

    always #5 clk = ~clk;

    // monitor: drain every posted expectation against what the DUTs present now
    initial forever begin
        @(chk);
        while (q.size() != 0) begin
            exp_t e;
            logic [6:0] act;
            e = q.pop_front();
            act = e.chan ? {c1_cntr, c0_cntr, c1_cy} : {3'b000, cntr, cy};
            if (e.chan && c1_cy === 1'b1) pulses++;
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b, expected %b", e.name, act, e.exp);
            end
        end
    end

    task automatic post(input string name, input bit chan, input logic [6:0] exp);
        q.push_back('{name, chan, exp});
        ->chk;
        #0;
    endtask

    task automatic cyc(input logic r, input logic e, input logic [2:0] ec, input logic ey, input string name);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        post(name, 1'b0, {3'b000, ec, ey});
    endtask

    task automatic comb(input logic r, input logic e, input logic [2:0] ec, input logic ey, input string name);
        rst = r;
        en  = e;
        #1;
        post(name, 1'b0, {3'b000, ec, ey});
    endtask

    initial begin
        cyc(0, 1, 0, 0, "reset_edge1");
        cyc(0, 1, 0, 0, "reset_edge2");
        cyc(1, 1, 1, 0, "count1");
        cyc(1, 1, 2, 0, "count2");
        cyc(1, 1, 3, 0, "count3");
        cyc(1, 1, 4, 0, "count4");
        cyc(1, 1, 5, 0, "count5");
        cyc(1, 1, 6, 0, "count6");
        cyc(1, 1, 7, 1, "count7_cy");
        cyc(1, 1, 0, 0, "wrap0");
        cyc(1, 1, 1, 0, "after_wrap1");
        cyc(1, 1, 2, 0, "after_wrap2");
        cyc(1, 1, 3, 0, "hold_start");
        for (int i = 0; i < 5; i++) cyc(1, 0, 3, 0, "hold");
        cyc(1, 1, 4, 0, "resume4");
        cyc(1, 1, 5, 0, "park5");
        cyc(1, 1, 6, 0, "park6");
        cyc(1, 1, 7, 1, "park7");
        comb(1, 0, 7, 0, "cy_en_low");
        comb(1, 1, 7, 1, "cy_en_high");
        comb(1, 0, 7, 0, "cy_en_low2");
        comb(0, 1, 7, 0, "cy_rst_comb");
        cyc(0, 1, 0, 0, "rst_from7");
        cyc(1, 1, 1, 0, "mid1");
        cyc(1, 1, 2, 0, "mid2");
        cyc(1, 1, 3, 0, "mid3");
        cyc(1, 1, 4, 0, "mid4");
        cyc(1, 1, 5, 0, "mid5");
        cyc(0, 1, 0, 0, "mid_reset");
        cyc(1, 1, 1, 0, "mid_resume");
        cyc(1, 0, 1, 0, "toggle_off1");
        cyc(1, 1, 2, 0, "toggle_on2");
        cyc(1, 0, 2, 0, "toggle_off2");
        cyc(1, 1, 3, 0, "toggle_on3");
        @(negedge clk);
        crst = 1;
        #1;
        post("cascade_start", 1'b1, 7'd0);
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            post("cascade", 1'b1, {6'(k % 64), 1'(k % 64 == 63)});
        end
        #20;
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL cascade_pulses: got %0d, expected 1", pulses);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
